// File: rtl/c_len_8_pkg.sv
// Literal encoding and slot helpers shared by the clause-length unit.
package clause_pkg;

    localparam logic [1:0] LIT_NONE = 2'b00;
    localparam logic [1:0] LIT_POS  = 2'b10;
    localparam logic [1:0] LIT_NEG  = 2'b01;
    localparam logic [1:0] LIT_BAD  = 2'b11;

    // Widest clause the slot helper can index (32 slots of 2 bits).
    localparam int CLAUSE_MAX_BITS = 64;

    typedef struct packed {
        logic is_lit;
        logic is_pos;
        logic is_neg;
        logic is_bad;
    } lit_flags_t;

    function automatic logic [1:0] get_lit(input logic [CLAUSE_MAX_BITS-1:0] clause,
                                           input int unsigned idx);
        return clause[2*idx +: 2];
    endfunction

endpackage

// File: rtl/c_len_8_lit_decode.sv
// Single-slot literal decoder: classifies one 2-bit slot of a packed clause.
module lit_decode
    import clause_pkg::*;
(
    input  logic [1:0] i_lit,
    output logic       o_is_lit,
    output logic       o_is_pos,
    output logic       o_is_neg,
    output logic       o_is_bad
);

    assign o_is_lit = (i_lit != LIT_NONE);
    assign o_is_pos = (i_lit == LIT_POS);
    assign o_is_neg = (i_lit == LIT_NEG);
    assign o_is_bad = (i_lit == LIT_BAD);

endmodule

// File: rtl/c_len_8.sv
// Clause-length unit: literal/polarity counts, unit/empty/malformed flags.
// Define C_LEN_REG_OUT_EN to register all outputs (1-cycle latency).
module c_len_8
    import clause_pkg::*;
#(
    parameter int NUM_VARS = 8,
    parameter int WIDTH    = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  valid_i,
    input  logic [NUM_VARS*2-1:0] clause_i,
    output logic                  valid_o,
    output logic [WIDTH-1:0]      len_o,
    output logic [WIDTH-1:0]      pos_cnt_o,
    output logic [WIDTH-1:0]      neg_cnt_o,
    output logic                  empty_o,
    output logic                  unit_o,
    output logic [WIDTH-1:0]      unit_idx_o,
    output logic                  malformed_o
);

    generate
        if (WIDTH < $clog2(NUM_VARS + 1)) begin : g_width_check
            $error("c_len_8: WIDTH too small to hold NUM_VARS");
        end
        if (NUM_VARS * 2 > CLAUSE_MAX_BITS) begin : g_size_check
            $error("c_len_8: NUM_VARS exceeds slot helper range");
        end
    endgenerate

    logic [CLAUSE_MAX_BITS-1:0] w_clause_ext;
    logic [NUM_VARS-1:0]        w_is_lit;
    logic [NUM_VARS-1:0]        w_is_pos;
    logic [NUM_VARS-1:0]        w_is_neg;
    logic [NUM_VARS-1:0]        w_is_bad;

    assign w_clause_ext = CLAUSE_MAX_BITS'(clause_i);

    genvar gi;
    generate
        for (gi = 0; gi < NUM_VARS; gi++) begin : g_slot
            logic [1:0] w_lit;
            assign w_lit = get_lit(w_clause_ext, gi);
            lit_decode u_dec (
                .i_lit    (w_lit),
                .o_is_lit (w_is_lit[gi]),
                .o_is_pos (w_is_pos[gi]),
                .o_is_neg (w_is_neg[gi]),
                .o_is_bad (w_is_bad[gi])
            );
        end
    endgenerate

    logic [WIDTH-1:0] w_len;
    logic [WIDTH-1:0] w_pos;
    logic [WIDTH-1:0] w_neg;
    logic [WIDTH-1:0] w_idx;
    logic             w_bad;
    logic             w_empty;
    logic             w_unit;

    always_comb begin
        w_len = '0;
        w_pos = '0;
        w_neg = '0;
        for (int i = 0; i < NUM_VARS; i++) begin
            w_len = w_len + WIDTH'(w_is_lit[i]);
            w_pos = w_pos + WIDTH'(w_is_pos[i]);
            w_neg = w_neg + WIDTH'(w_is_neg[i]);
        end
    end

    // Scan from the top down so the lowest nonzero slot wins.
    always_comb begin
        w_idx = '0;
        for (int i = NUM_VARS - 1; i >= 0; i--) begin
            if (w_is_lit[i]) begin
                w_idx = WIDTH'(i);
            end
        end
    end

    assign w_bad   = |w_is_bad;
    assign w_empty = ~|w_is_lit;
    assign w_unit  = (w_len == WIDTH'(1));

`ifdef C_LEN_REG_OUT_EN
    logic             r_valid;
    logic [WIDTH-1:0] r_len;
    logic [WIDTH-1:0] r_pos;
    logic [WIDTH-1:0] r_neg;
    logic [WIDTH-1:0] r_idx;
    logic             r_bad;
    logic             r_empty;
    logic             r_unit;

    // Data holds while idle; only the valid flag drops.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_len   <= '0;
            r_pos   <= '0;
            r_neg   <= '0;
            r_idx   <= '0;
            r_bad   <= 1'b0;
            r_empty <= 1'b1;
            r_unit  <= 1'b0;
        end else begin
            r_valid <= valid_i;
            if (valid_i) begin
                r_len   <= w_len;
                r_pos   <= w_pos;
                r_neg   <= w_neg;
                r_idx   <= w_idx;
                r_bad   <= w_bad;
                r_empty <= w_empty;
                r_unit  <= w_unit;
            end
        end
    end

    assign valid_o     = r_valid;
    assign len_o       = r_len;
    assign pos_cnt_o   = r_pos;
    assign neg_cnt_o   = r_neg;
    assign unit_idx_o  = r_idx;
    assign malformed_o = r_bad;
    assign empty_o     = r_empty;
    assign unit_o      = r_unit;
`else
    logic w_unused_clk_rst;
    assign w_unused_clk_rst = clk ^ rst;

    assign valid_o     = valid_i;
    assign len_o       = w_len;
    assign pos_cnt_o   = w_pos;
    assign neg_cnt_o   = w_neg;
    assign unit_idx_o  = w_idx;
    assign malformed_o = w_bad;
    assign empty_o     = w_empty;
    assign unit_o      = w_unit;
`endif

endmodule

// File: tb/tb_c_len_8.sv
// Directed + random bench for c_len_8 with a queue scoreboard; covers both output builds.
module tb_c_len_8;

    localparam int NV = 8;
    localparam int W  = 4;

    typedef struct packed {
        logic         valid;
        logic [W-1:0] len;
        logic [W-1:0] pos;
        logic [W-1:0] neg;
        logic         empty;
        logic         unit;
        logic [W-1:0] idx;
        logic         bad;
    } exp_t;

    logic            clk;
    logic            rst;
    logic            valid_i;
    logic [NV*2-1:0] clause_i;
    logic            valid_o;
    logic [W-1:0]    len_o;
    logic [W-1:0]    pos_cnt_o;
    logic [W-1:0]    neg_cnt_o;
    logic            empty_o;
    logic            unit_o;
    logic [W-1:0]    unit_idx_o;
    logic            malformed_o;

    int   checks = 0;
    int   errors = 0;
    exp_t sb_q[$];
    exp_t last_exp;
    exp_t reset_exp;

    c_len_8 #(.NUM_VARS(NV), .WIDTH(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .valid_i     (valid_i),
        .clause_i    (clause_i),
        .valid_o     (valid_o),
        .len_o       (len_o),
        .pos_cnt_o   (pos_cnt_o),
        .neg_cnt_o   (neg_cnt_o),
        .empty_o     (empty_o),
        .unit_o      (unit_o),
        .unit_idx_o  (unit_idx_o),
        .malformed_o (malformed_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic exp_t model(input logic [NV*2-1:0] c);
        exp_t e;
        logic [1:0] s;
        logic found;
        e = '0;
        found = 1'b0;
        for (int i = 0; i < NV; i++) begin
            s = c[2*i +: 2];
            if (s != 2'b00) begin
                e.len = e.len + 1'b1;
                if (!found) begin
                    e.idx = W'(i);
                    found = 1'b1;
                end
            end
            if (s == 2'b10) e.pos = e.pos + 1'b1;
            if (s == 2'b01) e.neg = e.neg + 1'b1;
            if (s == 2'b11) e.bad = 1'b1;
        end
        e.empty = (e.len == 0);
        e.unit  = (e.len == 1);
        return e;
    endfunction

    task automatic cmp(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle's inputs and push the result the DUT owes for them.
    task automatic drive(input logic [NV*2-1:0] c, input logic v, input logic r);
        exp_t e;
        @(negedge clk);
        clause_i = c;
        valid_i  = v;
        rst      = r;
`ifdef C_LEN_REG_OUT_EN
        if (r) begin
            e = reset_exp;
            last_exp = reset_exp;
        end else if (v) begin
            e = model(c);
            e.valid = 1'b1;
            last_exp = e;
        end else begin
            e = last_exp;
            e.valid = 1'b0;
        end
`else
        e = model(c);
        e.valid = v;
`endif
        sb_q.push_back(e);
    endtask

    task automatic collect(input string name);
        exp_t e;
`ifdef C_LEN_REG_OUT_EN
        @(posedge clk);
`endif
        #1;
        checks++;
        assert (sb_q.size() > 0) else begin
            errors++;
            $error("FAIL %s_queue observed=empty expected=entry", name);
        end
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            cmp({name, "_valid"}, 8'(valid_o),     8'(e.valid));
            cmp({name, "_len"},   8'(len_o),       8'(e.len));
            cmp({name, "_pos"},   8'(pos_cnt_o),   8'(e.pos));
            cmp({name, "_neg"},   8'(neg_cnt_o),   8'(e.neg));
            cmp({name, "_empty"}, 8'(empty_o),     8'(e.empty));
            cmp({name, "_unit"},  8'(unit_o),      8'(e.unit));
            cmp({name, "_idx"},   8'(unit_idx_o),  8'(e.idx));
            cmp({name, "_bad"},   8'(malformed_o), 8'(e.bad));
            $display("txn %s clause=%h valid=%0b len=%0d pos=%0d neg=%0d idx=%0d bad=%0b",
                     name, clause_i, valid_o, len_o, pos_cnt_o, neg_cnt_o, unit_idx_o, malformed_o);
        end
    endtask

    task automatic step(input string name, input logic [NV*2-1:0] c,
                        input logic v, input logic r);
        drive(c, v, r);
        collect(name);
    endtask

    initial begin
        exp_t k;
        rst      = 1'b1;
        valid_i  = 1'b0;
        clause_i = '0;
        reset_exp = '0;
        reset_exp.empty = 1'b1;
        last_exp = reset_exp;

        step("reset0", 16'h0000, 1'b0, 1'b1);
        step("reset1", 16'h0000, 1'b0, 1'b1);

        step("empty",   16'h0000, 1'b1, 1'b0);
        step("unit2",   16'h0020, 1'b1, 1'b0);
        step("full",    16'h9999, 1'b1, 1'b0);
        step("bad5",    16'h0C01, 1'b1, 1'b0);
        step("b2b_1",   16'h0002, 1'b1, 1'b0);
        step("b2b_2",   16'h000A, 1'b1, 1'b0);
        step("b2b_3",   16'h002A, 1'b1, 1'b0);
        step("idle",    16'h1234, 1'b0, 1'b0);
        step("top",     16'h8000, 1'b1, 1'b0);
        step("allbad",  16'hFFFF, 1'b1, 1'b0);

        // Hand-derived spot checks independent of the model function.
        k = model(16'h9999);
        cmp("const_full_len", 8'(k.len), 8'd8);
        k = model(16'h8000);
        cmp("const_top_idx",  8'(k.idx), 8'd7);

        for (int n = 0; n < 24; n++) begin
            step("rand", 16'($urandom), 1'b1, 1'b0);
        end

        step("rst_mid",  16'hFFFF, 1'b1, 1'b1);
        step("after_rst", 16'h0004, 1'b1, 1'b0);
        step("tail_idle", 16'h0000, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/c_len_8.md
Name: c_len_8

Overview:
- Clause-length unit for the SAT bin engine.
- Takes one packed clause (2 bits per variable) and reports how many literals it contains, plus polarity counts and unit/empty/malformed flags.
- Sits beside the clause array and feeds the clause length used when a loaded or learnt clause is written.
- Output timing is combinational by default; an optional registered output stage can be compiled in.

Parameters:
- NUM_VARS, default 8: number of variable slots in a clause.
- WIDTH, default 4: width of the count outputs. Must be at least ceil(log2(NUM_VARS+1)); a smaller value is an elaboration error.

Ports:
- clk  in  1: clock.
- rst  in  1: reset, synchronous, active-high.
- valid_i  in  1: clause_i is meaningful this cycle.
- clause_i  in  NUM_VARS*2: packed clause. Slot i is clause_i[2i+1:2i].
- valid_o  out  1: outputs correspond to a valid clause.
- len_o  out  WIDTH: number of nonzero slots.
- pos_cnt_o  out  WIDTH: number of slots equal to 2'b10.
- neg_cnt_o  out  WIDTH: number of slots equal to 2'b01.
- empty_o  out  1: len_o == 0.
- unit_o  out  1: len_o == 1.
- unit_idx_o  out  WIDTH: slot index of the lowest nonzero slot; 0 when the clause is empty.
- malformed_o  out  1: at least one slot equals 2'b11.

Behaviour:
- Slot encoding:
  - 2'b00: variable absent.
  - 2'b10: positive literal.
  - 2'b01: negative literal.
  - 2'b11: illegal. Counted in len_o, counted in neither pos_cnt_o nor neg_cnt_o, and asserts malformed_o.
- Invariant: len_o == pos_cnt_o + neg_cnt_o + (number of 2'b11 slots).
- Counts are exact, with no saturation. NUM_VARS=8 gives a maximum of 8 (4'b1000).
- unit_idx_o is a priority encode from slot 0 upward. It is valid whenever the clause is non-empty, not only when unit_o is set.
- Default build (macro undefined): all outputs are purely combinational functions of clause_i.
  - valid_o = valid_i.
  - clk and rst are unused apart from lint.
  - Outputs follow clause_i even when valid_i=0; consumers gate with valid_o.
- Empty clause (all 2'b00): len_o=0, empty_o=1, unit_o=0, unit_idx_o=0.
- Full clause (all slots nonzero): len_o=NUM_VARS, empty_o=0, unit_o=0.
- No state machine exists in either build.

Optional Feature:
- Macro C_LEN_REG_OUT_EN. When defined, all outputs are registered on the rising edge of clk, giving 1-cycle latency.
- Output register load rule:
  - Registers load when valid_i=1.
  - When valid_i=0, valid_o goes to 0 on the next edge and the data outputs hold their last values.
- Back-to-back valid_i produces one result per cycle, no bubbles.
- Reset values, with rst=1 sampled at an edge: valid_o=0, len_o=0, pos_cnt_o=0, neg_cnt_o=0, unit_idx_o=0, malformed_o=0, unit_o=0, empty_o=1.
- Reset mid-stream: rst has priority over valid_i. The clause presented in the reset cycle is discarded.
- When undefined: combinational behaviour as above.

Decomposition:
- Shared package clause_pkg:
  - Literal encoding constants LIT_NONE=2'b00, LIT_POS=2'b10, LIT_NEG=2'b01, LIT_BAD=2'b11.
  - A function returning the literal field at index i of a packed clause.
- One natural sub-module, lit_decode: decodes a single slot into is_lit, is_pos, is_neg, is_bad, instantiated NUM_VARS times.
- Adder tree and priority encoder live in c_len_8.

Test Plan:
1. clause_i=16'h0000, valid_i=1 -> len_o=0, empty_o=1, unit_o=0, unit_idx_o=0, malformed_o=0.
2. clause_i=16'h0020 (slot2=2'b10) -> len_o=1, unit_o=1, unit_idx_o=2, pos_cnt_o=1, neg_cnt_o=0.
3. clause_i=16'h9999 (slots alternate 01,10) -> len_o=8, pos_cnt_o=4, neg_cnt_o=4, unit_idx_o=0, empty_o=0.
4. clause_i=16'h0C01 (slot0=01, slot5=11) -> len_o=2, neg_cnt_o=1, pos_cnt_o=0, malformed_o=1, unit_idx_o=0.
5. C_LEN_REG_OUT_EN defined: rst=1 for 2 cycles, then clauses 16'h0002, 16'h000A, 16'h002A on consecutive cycles -> len_o = 1, 2, 3 one cycle after each, with valid_o=1. Then valid_i=0 -> valid_o=0 and len_o holds 3.
6. C_LEN_REG_OUT_EN defined: assert rst in the same cycle as valid_i=1 with clause 16'hFFFF -> next cycle valid_o=0, len_o=0, empty_o=1.
